// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif: I2C/SCCB target that turns bus transactions into register-bank
// strobes. Handles 8- or 16-bit register pointers, byte writes, byte reads and pointer
// auto-increment. SDA is open-drain (driven 0 or released), SCL is never stretched.
module i2c_slave_regif #(
  parameter logic [7:0] DEV_ID   = 8'h42,
  parameter int         FILT_LEN = 3,
  parameter int         HOLD_CYC = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  input  logic        addr_mode,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [7:0]  reg_rdata,
  output logic        busy,
  output logic        ack_err
);

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int HCW = $clog2(HOLD_CYC + 1);
  localparam logic [6:0] ID7 = DEV_ID[7:1];

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_ADDR_HI, S_ADDR_LO, S_ADDR_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACKCHK
  } state_t;

  state_t           state;
  logic [1:0]       scl_sync, sda_sync;
  logic [FCW-1:0]   scl_cnt, sda_cnt;
  logic             scl_f, sda_f, scl_q, sda_q;
  logic             scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0]       shreg;
  logic [7:0]       byte_in;
  logic [3:0]       bit_cnt;
  logic             mid_byte;
  logic             mode16;
  logic [7:0]       addr_hi;
  logic             lo_next;
  logic             is_read;
  logic             mack;
  logic             rd_d;
  logic             sda_pend;
  logic             sda_oe;
  logic [HCW-1:0]   hold_cnt;

  assign i2c_sdat   = sda_oe ? 1'b0 : 1'bz;
  assign scl_rise   = scl_f & ~scl_q;
  assign scl_fall   = ~scl_f & scl_q;
  assign start_cond = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_cond  = scl_f & scl_q & ~sda_q & sda_f;
  assign byte_in    = {shreg[6:0], sda_f};

  function automatic logic [15:0] next_addr(input logic [15:0] a, input logic m16);
    next_addr = m16 ? a + 16'd1 : {8'h00, a[7:0] + 8'd1};
  endfunction

  // Synchronise both bus lines, accept a level change only after FILT_LEN stable cycles
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], i2c_sclk};
      sda_sync <= {sda_sync[0], i2c_sdat};
      scl_q    <= scl_f;
      sda_q    <= sda_f;
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FCW'(FILT_LEN - 1)) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FCW'(FILT_LEN - 1)) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end

  // Protocol FSM, register strobes and delayed open-drain SDA drive
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      mid_byte  <= 1'b0;
      mode16    <= 1'b0;
      addr_hi   <= '0;
      lo_next   <= 1'b0;
      is_read   <= 1'b0;
      mack      <= 1'b0;
      rd_d      <= 1'b0;
      sda_pend  <= 1'b0;
      sda_oe    <= 1'b0;
      hold_cnt  <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
      ack_err   <= 1'b0;
    end else begin
      reg_wr  <= 1'b0;
      reg_rd  <= 1'b0;
      ack_err <= 1'b0;
      rd_d    <= reg_rd;
      if (reg_wr) reg_addr <= next_addr(reg_addr, mode16);
      if (rd_d) begin
        shreg    <= reg_rdata;
        sda_pend <= ~reg_rdata[7];
      end
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == HCW'(1)) sda_oe <= sda_pend;
      end

      if (start_cond) begin
        state    <= S_DEV;
        busy     <= 1'b1;
        mode16   <= addr_mode;
        bit_cnt  <= '0;
        mid_byte <= 1'b0;
        sda_pend <= 1'b0;
        sda_oe   <= 1'b0;
        hold_cnt <= '0;
        rd_d     <= 1'b0;
        ack_err  <= mid_byte;
      end else if (stop_cond) begin
        state    <= S_IDLE;
        busy     <= 1'b0;
        bit_cnt  <= '0;
        mid_byte <= 1'b0;
        sda_pend <= 1'b0;
        sda_oe   <= 1'b0;
        hold_cnt <= '0;
        rd_d     <= 1'b0;
        ack_err  <= mid_byte;
      end else begin
        if (scl_fall && state != S_IDLE) hold_cnt <= HCW'(HOLD_CYC);
        case (state)
          S_IDLE: begin
          end
          S_DEV, S_ADDR_HI, S_ADDR_LO, S_WR_DATA: begin
            if (scl_fall && bit_cnt != 4'd0) mid_byte <= 1'b1;
            if (scl_rise) begin
              shreg <= byte_in;
              if (bit_cnt != 4'd7) begin
                bit_cnt <= bit_cnt + 4'd1;
              end else begin
                bit_cnt  <= 4'd8;
                mid_byte <= 1'b0;
                if (state == S_DEV) begin
                  if (byte_in[7:1] == ID7) begin
                    is_read <= byte_in[0];
                    state   <= S_DEV_ACK;
                  end else begin
                    ack_err <= 1'b1;
                    state   <= S_IDLE;
                  end
                end else if (state == S_ADDR_HI) begin
                  if (mode16) begin
                    addr_hi <= byte_in;
                    lo_next <= 1'b1;
                  end else begin
                    reg_addr <= {8'h00, byte_in};
                    lo_next  <= 1'b0;
                  end
                  state <= S_ADDR_ACK;
                end else if (state == S_ADDR_LO) begin
                  reg_addr <= {addr_hi, byte_in};
                  lo_next  <= 1'b0;
                  state    <= S_ADDR_ACK;
                end else begin
                  reg_wdata <= byte_in;
                  reg_wr    <= 1'b1;
                  state     <= S_WR_ACK;
                end
              end
            end
          end
          S_DEV_ACK, S_ADDR_ACK, S_WR_ACK: begin
            if (scl_rise) bit_cnt <= 4'd9;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_pend <= 1'b1;
              end else begin
                sda_pend <= 1'b0;
                bit_cnt  <= '0;
                if (state == S_DEV_ACK) begin
                  if (is_read) begin
                    reg_rd <= 1'b1;
                    state  <= S_RD_DATA;
                  end else begin
                    state <= S_ADDR_HI;
                  end
                end else if (state == S_ADDR_ACK) begin
                  state <= lo_next ? S_ADDR_LO : S_WR_DATA;
                end else begin
                  state <= S_WR_DATA;
                end
              end
            end
          end
          S_RD_DATA: begin
            if (scl_rise) begin
              if (bit_cnt != 4'd7) begin
                bit_cnt <= bit_cnt + 4'd1;
              end else begin
                bit_cnt  <= 4'd8;
                mid_byte <= 1'b0;
                state    <= S_RD_ACKCHK;
              end
            end
            if (scl_fall && bit_cnt != 4'd0) begin
              mid_byte <= 1'b1;
              shreg    <= {shreg[6:0], shreg[7]};
              sda_pend <= ~shreg[6];
            end
          end
          S_RD_ACKCHK: begin
            if (scl_rise) begin
              bit_cnt <= 4'd9;
              mack    <= ~sda_f;
              if (!sda_f) reg_addr <= next_addr(reg_addr, mode16);
            end
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_pend <= 1'b0;
              end else begin
                bit_cnt <= '0;
                if (mack) begin
                  reg_rd <= 1'b1;
                  state  <= S_RD_DATA;
                end else begin
                  state <= S_IDLE;
                end
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
